pipeline_step_ctrl: RTL
=======================

# pipeline_step_ctrl

Execution controller that sequences the pipeline's step enable for the debug unit. Accepts RUN / STEP / PAUSE commands over a valid/ready handshake. Drives the single `o_step` enable consumed by every pipeline register (IF/ID onward). On a decoded HALT instruction it drains the pipeline for a fixed number of cycles and parks in a terminal HALTED state.

## Interface
Parameters:
- `DRAIN_CYCLES`, 4: step pulses issued after HALT detection so in-flight instructions retire (≥1).
- `CNT_BITS`, 32: width of the executed-cycle counter.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_cmd_valid`  in  1  command offered by debug unit.
- `i_cmd`  in  2  00 NOP, 01 RUN, 10 STEP, 11 PAUSE.
- `o_cmd_ready`  out  1  command accepted when valid & ready at a rising edge.
- `i_halt_detected`  in  1  HALT opcode present in ID stage (level).
- `o_step`  out  1  pipeline advance enable.
- `o_running`  out  1  high in RUN or DRAIN.
- `o_done`  out  1  one-cycle pulse: step finished, or drain finished.
- `o_halted`  out  1  high in HALTED.
- `o_cycle_count`  out  CNT_BITS  number of cycles with `o_step`=1 since reset.

## Operation
- States: IDLE, RUN, STEP, DRAIN, HALTED. Moore outputs decoded from registered state.
- Reset (`i_rst_n`=0 at edge): state IDLE, drain counter 0, `o_cycle_count`=0. `o_done`=0, `o_step`=0, `o_running`=0, `o_halted`=0, `o_cmd_ready`=1 after reset.
- Reset mid-operation wins over every other event, including an accepted command in the same cycle.
- `o_step` = 1 in RUN, STEP, DRAIN; 0 otherwise.
- `o_cmd_ready` = 1 in IDLE and RUN; 0 in STEP, DRAIN, HALTED.
- IDLE transitions:
  - RUN → RUN.
  - STEP → STEP.
  - NOP/PAUSE: accepted, no effect.
  - `i_halt_detected` ignored, because the pipeline is frozen.
- RUN transitions:
  - `i_halt_detected`=1 → DRAIN. This takes priority over a same-cycle PAUSE, and the PAUSE is still consumed.
  - Accepted PAUSE → IDLE with no drain. Pipeline state is preserved.
  - RUN/STEP/NOP: accepted, ignored.
- STEP: lasts exactly one cycle.
  - `i_halt_detected`=1 in that cycle → DRAIN.
  - Otherwise → IDLE with `o_done`=1 in the IDLE cycle.
- DRAIN:
  - Drain counter loads 0 on entry and increments every cycle.
  - After DRAIN_CYCLES cycles in DRAIN → HALTED, with `o_done`=1 for the first HALTED cycle.
  - Commands not accepted.
- HALTED: terminal until reset. `o_step`=0, all commands refused.
- Halt still pending after PAUSE: HALT stays in ID, so the first RUN cycle sees it → DRAIN. The same applies to STEP.
- Drain counter width: `$clog2(DRAIN_CYCLES+1)`.

## Timing
- Command accepted at edge N → `o_step`=1 in cycle N+1.
- STEP: `o_step` high for exactly cycle N+1; `o_done` in cycle N+2.
- PAUSE accepted at edge N while RUN → `o_step`=0 from cycle N+1. Exactly one RUN cycle overlaps the accepting cycle.
- HALT sampled at edge M in RUN → DRAIN_CYCLES step cycles M+1..M+DRAIN_CYCLES; HALTED and `o_done` at M+DRAIN_CYCLES+1.
- `o_cycle_count` updates on the edge ending each `o_step`=1 cycle, so it is visible one cycle later. It saturates at 2^CNT_BITS−1; no wrap.

## Configuration
- `STEP_CYCLE_COUNTER_EN` defined: cycle counter compiled in as specified.
- `STEP_CYCLE_COUNTER_EN` undefined: no counter flops; `o_cycle_count` tied to 0. All other behaviour identical.

## Structure
- Shared package `pipeline_ctrl_pkg`:
  - command code constants CMD_NOP/RUN/STEP/PAUSE;
  - state enum IDLE/RUN/STEP/DRAIN/HALTED.
- One sub-module: `sat_cycle_counter` (parameter width; enable, synchronous active-low clear, saturating). Instantiated only under `STEP_CYCLE_COUNTER_EN`.

## Test plan
- Reset, then STEP ×3 (DRAIN_CYCLES=4): one `o_step` pulse per command, `o_done` one cycle after each, `o_cycle_count`=3.
- RUN for 10 cycles then PAUSE: exactly 11 `o_step` cycles (RUN cycles plus the accepting cycle), IDLE, `o_cmd_ready`=1, count=11.
- RUN, assert `i_halt_detected` at cycle 5: 4 further step cycles, `o_done`+`o_halted` pulse/level next; all later commands refused (`o_cmd_ready`=0).
- Same cycle PAUSE and `i_halt_detected` in RUN: DRAIN taken, not IDLE.
- Pause with HALT held in ID, then STEP: single step enters DRAIN, reaches HALTED after 4 steps.
- Reset asserted during DRAIN: outputs return to reset values next cycle.
- Counter forced near max (CNT_BITS=4, 20 RUN cycles): saturates at 15.
- With macro undefined: counter stays 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - command codes and state encoding shared by the step controller
package pipeline_ctrl_pkg;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_PAUSE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DRAIN,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/sat_cycle_counter.sv
// rtl/sat_cycle_counter.sv - saturating up-counter with enable and synchronous active-low clear
module sat_cycle_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q;

  // Count enabled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      count_q <= '0;
    end else if (i_en && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pipeline_step_ctrl.sv
// rtl/pipeline_step_ctrl.sv - debug run/step/pause sequencer with HALT drain; STEP_CYCLE_COUNTER_EN adds the step-cycle counter
module pipeline_step_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_BITS     = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd,
  output logic                o_cmd_ready,
  input  logic                i_halt_detected,
  output logic                o_step,
  output logic                o_running,
  output logic                o_done,
  output logic                o_halted,
  output logic [CNT_BITS-1:0] o_cycle_count
);

  localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

  state_t            state;
  logic [DCNT_W-1:0] drain_cnt;
  logic              step_q;
  logic              running_q;
  logic              done_q;
  logic              halted_q;
  logic              ready_q;
  logic              cmd_acc;

  assign cmd_acc = i_cmd_valid && ready_q;

  // State machine; outputs are registered alongside each transition so they
  // always match the state they describe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      step_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // Pipeline frozen here, so a HALT sitting in ID is left for later.
          if (cmd_acc && (i_cmd == CMD_RUN)) begin
            state     <= ST_RUN;
            step_q    <= 1'b1;
            running_q <= 1'b1;
          end else if (cmd_acc && (i_cmd == CMD_STEP)) begin
            state   <= ST_STEP;
            step_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          // HALT beats a same-cycle PAUSE; the PAUSE is still consumed.
          if (i_halt_detected) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
            ready_q   <= 1'b0;
          end else if (cmd_acc && (i_cmd == CMD_PAUSE)) begin
            state     <= ST_IDLE;
            step_q    <= 1'b0;
            running_q <= 1'b0;
          end
        end
        ST_STEP: begin
          if (i_halt_detected) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
            running_q <= 1'b1;
          end else begin
            state   <= ST_IDLE;
            step_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= ST_HALTED;
            step_q    <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCNT_W'(1);
          end
        end
        ST_HALTED: begin
        end
        default: begin
          state     <= ST_IDLE;
          drain_cnt <= '0;
          step_q    <= 1'b0;
          running_q <= 1'b0;
          halted_q  <= 1'b0;
          ready_q   <= 1'b1;
        end
      endcase
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_step      = step_q;
  assign o_running   = running_q;
  assign o_done      = done_q;
  assign o_halted    = halted_q;

`ifdef STEP_CYCLE_COUNTER_EN
  sat_cycle_counter #(
    .WIDTH (CNT_BITS)
  ) u_cycle_counter (
    .i_clk   (i_clk),
    .i_clr_n (i_rst_n),
    .i_en    (step_q),
    .o_count (o_cycle_count)
  );
`else
  assign o_cycle_count = '0;
`endif

endmodule
